// File: rtl/md_pkg.sv
// Shared force-writeback ring types: default widths, packet layout, node id helper.
package md_pkg;

  localparam int unsigned NUM_CELLS_DEF         = 64;
  localparam int unsigned DATA_WIDTH_DEF        = 32;
  localparam int unsigned PARTICLE_ID_WIDTH_DEF = 7;

  // Destination field width; a one-node ring still needs a 1-bit field.
  function automatic int unsigned node_id_width(input int unsigned num_cells);
    return (num_cells > 1) ? $clog2(num_cells) : 1;
  endfunction

  localparam int unsigned NODE_ID_WIDTH_DEF = node_id_width(NUM_CELLS_DEF);

  // Payload written into the force cache: particle address plus force tuple.
  typedef struct packed {
    logic [PARTICLE_ID_WIDTH_DEF-1:0] pid;
    logic [DATA_WIDTH_DEF-1:0]        fx;
    logic [DATA_WIDTH_DEF-1:0]        fy;
    logic [DATA_WIDTH_DEF-1:0]        fz;
  } force_data_t;

  // Ring packet: destination node on top, payload below.
  typedef struct packed {
    logic [NODE_ID_WIDTH_DEF-1:0] dst;
    force_data_t                  force_data;
  } packet_t;

  localparam int unsigned FORCE_DATA_WIDTH_DEF = $bits(force_data_t);
  localparam int unsigned PACKET_WIDTH_DEF     = $bits(packet_t);

endpackage

// File: rtl/ring_inject_fifo.sv
// Registered synchronous FIFO with asynchronously reset pointers and occupancy.
// Head entry is presented combinationally from storage; push is ignored when
// full and pop is ignored when empty.
module ring_inject_fifo
  import md_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = PACKET_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_data = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy state; reset clears the FIFO logically.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ring_node.sv
// One node of the unidirectional force-writeback ring. Transit traffic is never
// stalled; local packets queue in an injection FIFO and use free ring slots or
// idle eject cycles. All outputs are registered.
module ring_node
  import md_pkg::*;
#(
  parameter int unsigned NUM_CELLS         = NUM_CELLS_DEF,
  parameter int unsigned NODE_ID           = 0,
  parameter int unsigned DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int unsigned PARTICLE_ID_WIDTH = PARTICLE_ID_WIDTH_DEF,
  parameter int unsigned NODE_ID_WIDTH     = node_id_width(NUM_CELLS),
  parameter int unsigned FORCE_DATA_WIDTH  = 3 * DATA_WIDTH + PARTICLE_ID_WIDTH,
  parameter int unsigned PACKET_WIDTH      = FORCE_DATA_WIDTH + NODE_ID_WIDTH,
  parameter int unsigned INJ_FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PACKET_WIDTH-1:0]     packet_in,
  input  logic                        packet_valid,
  output logic                        ready,
  input  logic [PACKET_WIDTH-1:0]     ring_in,
  input  logic                        ring_in_valid,
  output logic [PACKET_WIDTH-1:0]     ring_out,
  output logic                        ring_out_valid,
  output logic [FORCE_DATA_WIDTH-1:0] data_out,
  output logic                        data_valid,
  output logic                        node_empty
);

  localparam logic [NODE_ID_WIDTH-1:0] MyId = NODE_ID_WIDTH'(NODE_ID);

  logic [PACKET_WIDTH-1:0]     head_pkt;
  logic                        fifo_full, fifo_empty;
  logic                        fifo_push, fifo_pop;

  logic [NODE_ID_WIDTH-1:0]    ring_dst, head_dst;
  logic                        ring_eject, ring_fwd;
  logic                        head_self, local_eject, local_inject;

  logic [PACKET_WIDTH-1:0]     ring_out_q, ring_out_d;
  logic                        ring_out_valid_q, ring_out_valid_d;
  logic [FORCE_DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                        data_valid_q, data_valid_d;

  // ready depends on registered occupancy only, so a same-cycle pop cannot
  // open a full FIFO to a push.
  assign ready     = ~fifo_full;
  assign fifo_push = packet_valid & ready;

  ring_inject_fifo #(
    .DEPTH (INJ_FIFO_DEPTH),
    .WIDTH (PACKET_WIDTH)
  ) u_inj_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (packet_in),
    .pop       (fifo_pop),
    .head_data (head_pkt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ring_dst = ring_in[PACKET_WIDTH-1 -: NODE_ID_WIDTH];
  assign head_dst = head_pkt[PACKET_WIDTH-1 -: NODE_ID_WIDTH];

  // Route classification: ring traffic first, then the FIFO head takes
  // whichever resource (eject port or ring slot) the ring left unused.
  always_comb begin
    ring_eject   = ring_in_valid & (ring_dst == MyId);
    ring_fwd     = ring_in_valid & (ring_dst != MyId);
    head_self    = ~fifo_empty & (head_dst == MyId);
    local_eject  = head_self & ~ring_eject;
    local_inject = ~fifo_empty & ~head_self & ~ring_fwd;
    fifo_pop     = local_eject | local_inject;
  end

  // Output next-state: payload registers hold their value when not loaded.
  always_comb begin
    ring_out_d       = ring_out_q;
    ring_out_valid_d = 1'b0;
    data_out_d       = data_out_q;
    data_valid_d     = 1'b0;

    if (ring_eject) begin
      data_out_d   = ring_in[FORCE_DATA_WIDTH-1:0];
      data_valid_d = 1'b1;
    end else if (local_eject) begin
      data_out_d   = head_pkt[FORCE_DATA_WIDTH-1:0];
      data_valid_d = 1'b1;
    end

    if (ring_fwd) begin
      ring_out_d       = ring_in;
      ring_out_valid_d = 1'b1;
    end else if (local_inject) begin
      ring_out_d       = head_pkt;
      ring_out_valid_d = 1'b1;
    end
  end

  // Output registers; reset drops valids and clears payloads immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_out_q       <= '0;
      ring_out_valid_q <= 1'b0;
      data_out_q       <= '0;
      data_valid_q     <= 1'b0;
    end else begin
      ring_out_q       <= ring_out_d;
      ring_out_valid_q <= ring_out_valid_d;
      data_out_q       <= data_out_d;
      data_valid_q     <= data_valid_d;
    end
  end

  assign ring_out       = ring_out_q;
  assign ring_out_valid = ring_out_valid_q;
  assign data_out       = data_out_q;
  assign data_valid     = data_valid_q;

  // Drain indicator, built from registered state only.
  assign node_empty = fifo_empty & ~ring_out_valid_q & ~data_valid_q;

endmodule

// File: tb/tb_ring_node.sv
// Directed bench for ring_node at NODE_ID=3 with default widths.
module tb_ring_node;
  import md_pkg::*;

  localparam int unsigned MyNode = 3;
  localparam int unsigned PW     = PACKET_WIDTH_DEF;
  localparam int unsigned FW     = FORCE_DATA_WIDTH_DEF;
  localparam int unsigned NIW    = NODE_ID_WIDTH_DEF;

  localparam logic [31:0] F1 = 32'h3F80_0000;  // 1.0
  localparam logic [31:0] F2 = 32'h4000_0000;  // 2.0
  localparam logic [31:0] F3 = 32'h4040_0000;  // 3.0

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] packet_in;
  logic          packet_valid;
  logic          ready;
  logic [PW-1:0] ring_in;
  logic          ring_in_valid;
  logic [PW-1:0] ring_out;
  logic          ring_out_valid;
  logic [FW-1:0] data_out;
  logic          data_valid;
  logic          node_empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ring_node #(
    .NODE_ID (MyNode)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .packet_in      (packet_in),
    .packet_valid   (packet_valid),
    .ready          (ready),
    .ring_in        (ring_in),
    .ring_in_valid  (ring_in_valid),
    .ring_out       (ring_out),
    .ring_out_valid (ring_out_valid),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .node_empty     (node_empty)
  );

  // Destinations must name a real node.
  always @(posedge clk) begin
    if (ring_in_valid) assert (int'(ring_in[PW-1 -: NIW]) < NUM_CELLS_DEF);
    if (packet_valid)  assert (int'(packet_in[PW-1 -: NIW]) < NUM_CELLS_DEF);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic packet_t mk_pkt(input int unsigned dst, input int unsigned pid,
                                     input logic [31:0] fx, input logic [31:0] fy,
                                     input logic [31:0] fz);
    packet_t p;
    p.dst            = NIW'(dst);
    p.force_data.pid = 7'(pid);
    p.force_data.fx  = fx;
    p.force_data.fy  = fy;
    p.force_data.fz  = fz;
    return p;
  endfunction

  function automatic packet_t transit_pkt(input int unsigned i);
    return mk_pkt(5, 32'h20 + i, i, i + 1, i + 2);
  endfunction

  function automatic packet_t local_pkt(input int unsigned k);
    return mk_pkt(9, 32'h40 + k, 32'h100 + k, 32'h200 + k, 32'h300 + k);
  endfunction

  packet_t p, q, s_pkt;
  int      k;
  logic    acc;

  initial begin
    rst           = 1'b1;
    packet_in     = '0;
    packet_valid  = 1'b0;
    ring_in       = '0;
    ring_in_valid = 1'b0;

    // Reset state while held, before any clock edge.
    #3;
    check_eq("rst_ready",      ready,          1);
    check_eq("rst_empty",      node_empty,     1);
    check_eq("rst_ring_valid", ring_out_valid, 0);
    check_eq("rst_data_valid", data_valid,     0);
    check_eq("rst_ring_out",   ring_out,       0);
    check_eq("rst_data_out",   data_out,       0);
    #9 rst = 1'b0;
    tick();

    // Transit hop: dst=5 passes through unchanged.
    p = mk_pkt(5, 8'h12, F1, F2, F3);
    ring_in = p; ring_in_valid = 1'b1;
    tick();
    ring_in_valid = 1'b0;
    check_eq("fwd_valid",      ring_out_valid, 1);
    check_eq("fwd_pkt",        ring_out,       p);
    check_eq("fwd_data_valid", data_valid,     0);
    tick();
    check_eq("fwd_valid_drop", ring_out_valid, 0);

    // Ring eject: dst=3 strips dst and writes the payload.
    p = mk_pkt(3, 8'h05, F1, F2, F3);
    ring_in = p; ring_in_valid = 1'b1;
    tick();
    ring_in_valid = 1'b0;
    check_eq("ej_valid",      data_valid,     1);
    check_eq("ej_data",       data_out,       p.force_data);
    check_eq("ej_ring_valid", ring_out_valid, 0);
    tick();
    check_eq("ej_valid_drop", data_valid, 0);

    // Local injection on an idle ring: two-edge latency, single-cycle valid.
    p = mk_pkt(7, 8'h31, F3, F2, F1);
    packet_in = p; packet_valid = 1'b1;
    check_eq("inj_ready", ready, 1);
    tick();
    packet_valid = 1'b0;
    check_eq("inj_e0_valid", ring_out_valid, 0);
    check_eq("inj_e0_empty", node_empty,     0);
    tick();
    check_eq("inj_e1_valid", ring_out_valid, 1);
    check_eq("inj_e1_pkt",   ring_out,       p);
    tick();
    check_eq("inj_e2_valid", ring_out_valid, 0);
    check_eq("inj_e2_empty", node_empty,     1);

    // Ten cycles of transit while pushing five local packets: FIFO fills at 4.
    k = 0;
    for (int i = 0; i < 10; i++) begin
      ring_in       = transit_pkt(i);
      ring_in_valid = 1'b1;
      packet_in     = local_pkt(k);
      packet_valid  = (k < 5);
      check_eq("busy_ready", ready, (i < 4) ? 1 : 0);
      acc = packet_valid & ready;
      tick();
      if (acc) k++;
      check_eq("busy_valid", ring_out_valid, 1);
      check_eq("busy_pkt",   ring_out,       transit_pkt(i));
    end
    check_eq("busy_accepts", k, 4);
    ring_in_valid = 1'b0;
    // Ring idle: one injection per cycle in FIFO order; 5th push lands after first pop.
    for (int j = 0; j < 5; j++) begin
      acc = packet_valid & ready;
      tick();
      if (acc) begin
        k++;
        packet_in    = local_pkt(k);
        packet_valid = (k < 5);
      end
      check_eq("drain_valid", ring_out_valid, 1);
      check_eq("drain_pkt",   ring_out,       local_pkt(j));
      if (j == 0) check_eq("drain_ready_back", ready, 1);
    end
    packet_valid = 1'b0;
    check_eq("drain_accepts", k, 5);
    tick();
    check_eq("drain_valid_end", ring_out_valid, 0);
    check_eq("drain_empty",     node_empty,     1);

    // Ring eject and self-destined local head collide: ring first, local next.
    q = mk_pkt(3, 8'h33, F2, F2, F2);
    p = mk_pkt(3, 8'h44, F1, F1, F1);
    packet_in = q; packet_valid = 1'b1;
    tick();
    packet_valid = 1'b0;
    ring_in = p; ring_in_valid = 1'b1;
    tick();
    ring_in_valid = 1'b0;
    check_eq("col_ring_valid", data_valid,     1);
    check_eq("col_ring_data",  data_out,       p.force_data);
    check_eq("col_no_inject",  ring_out_valid, 0);
    tick();
    check_eq("col_local_valid", data_valid, 1);
    check_eq("col_local_data",  data_out,   q.force_data);
    tick();
    check_eq("col_valid_end", data_valid, 0);
    check_eq("col_empty",     node_empty, 1);

    // Build FIFO depth 3 with both outputs valid, then reset mid-cycle.
    s_pkt = mk_pkt(3, 8'h50, F3, F3, F3);
    ring_in = mk_pkt(3, 8'h60, F1, F2, F3); ring_in_valid = 1'b1;
    packet_in = s_pkt; packet_valid = 1'b1;
    tick();
    packet_in = local_pkt(10);
    tick();
    packet_in = local_pkt(11);
    tick();
    packet_in = local_pkt(12);
    ring_in = transit_pkt(20);
    tick();
    packet_valid  = 1'b0;
    ring_in_valid = 1'b0;
    check_eq("pre_rst_ring_valid", ring_out_valid, 1);
    check_eq("pre_rst_data_valid", data_valid,     1);
    check_eq("pre_rst_data",       data_out,       s_pkt.force_data);
    check_eq("pre_rst_empty",      node_empty,     0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ring_valid", ring_out_valid, 0);
    check_eq("arst_data_valid", data_valid,     0);
    check_eq("arst_ready",      ready,          1);
    check_eq("arst_empty",      node_empty,     1);
    check_eq("arst_ring_out",   ring_out,       0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_rst_ring_valid", ring_out_valid, 0);
      check_eq("post_rst_data_valid", data_valid,     0);
      check_eq("post_rst_empty",      node_empty,     1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ring_node.md
Name: ring_node

Overview:
- One node of the unidirectional force-writeback ring, instantiated NUM_CELLS times, one per cell/PE.
- Takes routed force packets from its local PE (after destination mapping) into a small injection FIFO.
- Forwards transit packets to the next node and ejects packets addressed to its own node to the local force cache write port.
- Bufferless in the ring direction: transit traffic never stalls. A per-node empty flag lets the top level detect drain exactly, with no fixed wait count.

Parameters:
- NUM_CELLS, 64, nodes on ring
- NODE_ID, 0, this node's index (0..NUM_CELLS-1)
- DATA_WIDTH, 32, force component width
- PARTICLE_ID_WIDTH, 7, particle address width in force cache
- NODE_ID_WIDTH, $clog2(NUM_CELLS), destination field width
- FORCE_DATA_WIDTH, 3*DATA_WIDTH+PARTICLE_ID_WIDTH, ejected payload width
- PACKET_WIDTH, FORCE_DATA_WIDTH+NODE_ID_WIDTH, packet width
- INJ_FIFO_DEPTH, 4, local injection FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- packet_in  in  PACKET_WIDTH  local packet {dst, force_data}
- packet_valid  in  1  local packet valid
- ready  out  1  local FIFO can accept; transfer on packet_valid & ready
- ring_in  in  PACKET_WIDTH  packet from previous node's ring_out
- ring_in_valid  in  1  ring_in valid
- ring_out  out  PACKET_WIDTH  packet to next node
- ring_out_valid  out  1  ring_out valid
- data_out  out  FORCE_DATA_WIDTH  ejected payload (dst stripped)
- data_valid  out  1  write enable to force cache
- node_empty  out  1  FIFO empty, ring_out_valid=0 and data_valid=0

Behaviour:
- One clock; reset is asynchronous and active-high. On rst assertion, immediately (no clock edge):
  - ring_out_valid=0, data_valid=0
  - FIFO pointers and count = 0
  - ring_out and data_out = 0
  - ready=1 and node_empty=1 while reset is held.
- ready = (count != INJ_FIFO_DEPTH), purely registered state (no combinational path from packet_valid). A push is accepted only when ready=1 at the start of the cycle. A simultaneous pop does not make a full FIFO accept.
- Each cycle, the following are resolved in priority order; all outputs are registered.
  1. Ring eject. If ring_in_valid and ring_in.dst==NODE_ID: data_out <= ring_in.force, data_valid <= 1. Ring slot becomes free.
  2. Ring forward. If ring_in_valid and dst!=NODE_ID: ring_out <= ring_in, ring_out_valid <= 1. Ring slot occupied.
  3. Local head, dst==NODE_ID (self-destined). Ejects via data_out only if step 1 did not eject this cycle; otherwise it waits. It does not use the ring slot.
  4. Local head, dst!=NODE_ID. Injects into ring_out only if the ring slot is free; otherwise it waits.
  - Otherwise: ring_out_valid <= 0 and/or data_valid <= 0.
- At most one FIFO pop per cycle. FIFO order is strict; the head blocks later entries (no bypass).
- Latency:
  - Ring hop (ring_in to ring_out): 1 cycle.
  - Ring eject (ring_in to data_out): 1 cycle.
  - Local accept at edge N: earliest ring_out or data_out is valid after edge N+1. Packets are written to the FIFO only, never bypassed past it.
- Transit priority is absolute; injection may be delayed indefinitely under continuous transit traffic. This is acceptable because PE force traffic is finite per reference particle.
- dst values ≥ NUM_CELLS are illegal. The bench asserts this never occurs; the RTL behaviour for them is undefined.
- FIFO pointers wrap modulo INJ_FIFO_DEPTH. count has width $clog2(INJ_FIFO_DEPTH)+1.
- node_empty is combinational from registered state only. The top level ANDs all node_empty flags for drain detection.

Decomposition:
- md_pkg holds:
  - packet_t (packed: dst [NODE_ID_WIDTH], force_data_t)
  - force_data_t (particle id + force tuple, already shared)
  - NODE_ID_WIDTH derivation.
- Natural sub-module: ring_inject_fifo. A registered synchronous FIFO with async-reset pointers, count, full/empty, and push/pop. It is reused wherever PE-side buffering is needed.
- ring_node holds the routing/arbitration and output registers only.

Test Plan:
- NODE_ID=3, ring_in_valid with dst=5, payload id=0x12 -> next cycle ring_out_valid=1 with identical packet, data_valid=0.
- NODE_ID=3, ring_in dst=3, force {1.0,2.0,3.0}, id=0x05 -> next cycle data_valid=1, data_out={id 0x05, forces}, ring_out_valid=0.
- Idle ring, local packet dst=7 accepted at edge 0 -> ring_out_valid=1 after edge 1 for exactly one cycle. node_empty returns to 1 after edge 2.
- Continuous forwarding traffic for 10 cycles while pushing 5 local packets (dst=9):
  - ready drops after 4 accepts, and the 5th is held by the bench.
  - No injection occurs during the traffic.
  - Injections follow in FIFO order, one per free slot, once the ring goes idle.
  - ready returns to 1 after the first pop.
- Same cycle: ring_in dst=NODE_ID and local self-destined head -> ring payload ejects first, local payload ejects the following cycle, and there is no loss.
- Assert rst asynchronously mid-cycle with the FIFO holding 3 entries and both outputs valid -> all valids drop before the next edge, ready=1, node_empty=1. After deassertion, no stale packets appear.
